// File: rtl/fir_filter.sv
// fir_filter: 8-tap direct-form FIR low-pass filter, one sample per clock.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - asynchronous, active-high; clears delay line and output
//   data_in  - N-bit signed input sample, taken on every rising edge
//   data_out - N-bit signed filtered output, registered, rounded and saturated
//
// Each fir_tap holds one delay-line register and its constant product; the
// taps are chained so tap 0 sees the newest sample and tap 7 the oldest.

module fir_tap #(
  parameter int N    = 16,
  parameter int COEF = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [N-1:0]   d,
  output logic signed [N-1:0]   q,
  output logic signed [2*N-1:0] prod
);
  localparam logic signed [N-1:0] C = N'(COEF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  // Widen both operands first so the multiply is a full signed 16x16->32.
  assign prod = (2*N)'(q) * (2*N)'(C);
endmodule

module fir_filter #(
  parameter int N  = 16,
  parameter int H0 = 1024,
  parameter int H1 = 2048,
  parameter int H2 = 4096,
  parameter int H3 = 8192,
  parameter int H4 = 8192,
  parameter int H5 = 4096,
  parameter int H6 = 2048,
  parameter int H7 = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [N-1:0] data_in,
  output logic signed [N-1:0] data_out
);
  localparam int TAPS  = 8;
  // Eight 32-bit products need 3 growth bits; one spare keeps rounding safe.
  localparam int ACC_W = 2*N + 4;
  localparam int COEF [TAPS] = '{H0, H1, H2, H3, H4, H5, H6, H7};

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (N-2);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2**(N-1) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(2**(N-1));

  logic signed [N-1:0]     din  [TAPS];
  logic signed [N-1:0]     q    [TAPS];
  logic signed [2*N-1:0]   prod [TAPS];
  logic signed [ACC_W-1:0] acc, rnd, shifted;
  logic signed [N-1:0]     y;

  assign din[0] = data_in;

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    if (i > 0) begin : g_link
      assign din[i] = q[i-1];
    end
    fir_tap #(.N(N), .COEF(COEF[i])) u_tap (
      .clk  (clk),
      .reset(reset),
      .d    (din[i]),
      .q    (q[i]),
      .prod (prod[i])
    );
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + ACC_W'(prod[i]);
    // Round half up: bias by 0.5 LSB then floor via arithmetic shift.
    rnd     = acc + HALF;
    shifted = rnd >>> (N-1);
    if (shifted > MAXV)      y = MAXV[N-1:0];
    else if (shifted < MINV) y = MINV[N-1:0];
    else                     y = shifted[N-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else       data_out <= y;
  end
endmodule

// File: tb/tb_fir_filter.sv
module tb_fir_filter;
  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] data_in;
  logic signed [15:0] dout_d, dout_s;

  int checks = 0;
  int errors = 0;

  int HD [8] = '{1024, 2048, 4096, 8192, 8192, 4096, 2048, 1024};
  int HS [8] = '{1024, 2048, 4096, 32767, 32767, 4096, 2048, 1024};

  logic signed [15:0] hist [8];
  logic signed [15:0] exp_d, exp_s;

  always #5 clk = ~clk;

  fir_filter u_def (.clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_d));
  fir_filter #(.H3(32767), .H4(32767)) u_sat (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(dout_s));

  // Reference: y = sat(floor((sum h*x + 2^14) / 2^15)) in plain 64-bit math.
  function automatic logic signed [15:0] model(input int h [8], input logic signed [15:0] x [8]);
    longint acc = 0;
    for (int i = 0; i < 8; i++) acc += longint'(h[i]) * longint'(x[i]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  // Drive one sample, advance one clock, update model; returns at edge+1.
  task automatic step(input logic signed [15:0] v);
    data_in = v;
    @(posedge clk);
    exp_d = model(HD, hist);
    exp_s = model(HS, hist);
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 9; i++) step(16'sd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) step(16'sd20000);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (dout_d !== 16'sd0) begin errors++; $display("FAIL reset_async_def: got %0d want 0", dout_d); end
    checks++;
    if (dout_s !== 16'sd0) begin errors++; $display("FAIL reset_async_sat: got %0d want 0", dout_s); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    data_in = 16'sd0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(16'sd0);
      checks++;
      if (dout_d !== 16'sd0) begin errors++; $display("FAIL reset_release cyc %0d: got %0d want 0", i, dout_d); end
    end
  endtask

  task automatic test_impulse();
    int tbl [9] = '{512, 1024, 2048, 4096, 4096, 2048, 1024, 512, 0};
    flush();
    step(16'sd16384);
    checks++;
    if (dout_d !== 16'sd0) begin errors++; $display("FAIL impulse_latency: got %0d want 0", dout_d); end
    for (int i = 0; i < 9; i++) begin
      step(16'sd0);
      checks++;
      if (dout_d !== 16'(tbl[i])) begin errors++; $display("FAIL impulse tap %0d: got %0d want %0d", i, dout_d, tbl[i]); end
      checks++;
      if (dout_s !== exp_s) begin errors++; $display("FAIL impulse_sat tap %0d: got %0d want %0d", i, dout_s, exp_s); end
    end
  endtask

  task automatic test_dc();
    logic signed [15:0] lv [2] = '{16'sd32767, -16'sd32768};
    int want [2] = '{30719, -30720};
    for (int k = 0; k < 2; k++) begin
      flush();
      for (int i = 0; i < 10; i++) begin
        step(lv[k]);
        checks++;
        if (dout_d !== exp_d) begin errors++; $display("FAIL dc%0d cyc %0d: got %0d want %0d", k, i, dout_d, exp_d); end
      end
      checks++;
      if (dout_d !== 16'(want[k])) begin errors++; $display("FAIL dc%0d_settle: got %0d want %0d", k, dout_d, want[k]); end
    end
  endtask

  task automatic test_rounding();
    int tbl [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    flush();
    step(16'sd3);
    for (int i = 0; i < 8; i++) begin
      step(16'sd0);
      checks++;
      if (dout_d !== 16'(tbl[i])) begin errors++; $display("FAIL round3 tap %0d: got %0d want %0d", i, dout_d, tbl[i]); end
    end
    step(-16'sd2);
    for (int i = 0; i < 8; i++) begin
      step(16'sd0);
      checks++;
      if (dout_d !== 16'sd0) begin errors++; $display("FAIL round_neg2 tap %0d: got %0d want 0", i, dout_d); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] lv [2] = '{16'sd32767, -16'sd32768};
    for (int k = 0; k < 2; k++) begin
      flush();
      for (int i = 0; i < 10; i++) begin
        step(lv[k]);
        checks++;
        if (dout_s !== exp_s) begin errors++; $display("FAIL sat%0d cyc %0d: got %0d want %0d", k, i, dout_s, exp_s); end
        // A wrapped value would show the wrong sign during the ramp.
        checks++;
        if ((k == 0 && dout_s < 0) || (k == 1 && dout_s > 0)) begin
          errors++; $display("FAIL sat%0d_wrap cyc %0d: got %0d", k, i, dout_s);
        end
      end
      checks++;
      if (dout_s !== lv[k]) begin errors++; $display("FAIL sat%0d_settle: got %0d want %0d", k, dout_s, lv[k]); end
    end
  endtask

  task automatic test_sine();
    logic signed [15:0] tbl [32];
    logic signed [15:0] outs [128];
    for (int i = 0; i < 32; i++) tbl[i] = 16'($rtoi(30000.0 * $sin(6.283185307179586 * i / 32.0)));
    flush();
    for (int i = 0; i < 128; i++) begin
      step(tbl[i % 32]);
      outs[i] = dout_d;
      checks++;
      if (dout_d !== exp_d) begin errors++; $display("FAIL sine cyc %0d: got %0d want %0d", i, dout_d, exp_d); end
    end
    for (int i = 64; i < 128; i++) begin
      checks++;
      if (outs[i] !== outs[i-32]) begin errors++; $display("FAIL sine_period cyc %0d: got %0d want %0d", i, outs[i], outs[i-32]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(16'($urandom));
      checks++;
      if (dout_d !== exp_d) begin errors++; $display("FAIL rand_def cyc %0d: got %0d want %0d", i, dout_d, exp_d); end
      checks++;
      if (dout_s !== exp_s) begin errors++; $display("FAIL rand_sat cyc %0d: got %0d want %0d", i, dout_s, exp_s); end
    end
  endtask

  initial begin
    reset = 1'b1;
    data_in = '0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    exp_d = '0;
    exp_s = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout_d !== 16'sd0) begin errors++; $display("FAIL init_reset: got %0d want 0", dout_d); end
    reset = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_rounding();
    test_saturation();
    test_sine();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
